dbus_responder: RTL

- Memory-side responder for the core's data bus: accepts dbus_req_t from the core's memory stage and returns dbus_resp_t.
- Backs a word-addressed 64-bit RAM window with byte-strobed writes and programmable response latency.
- Used as the simulation and FPGA data-memory endpoint for the pipeline's MMIO-free RAM region.
- Also serves as a latency source for exercising the core's stall_m logic.

---
 rtl/dbus_responder_pkg.sv | 36 +++
 rtl/dbus_responder_if.sv | 12 +
 rtl/dbus_resp_ram.sv | 32 +++
 rtl/dbus_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the data-bus responder.
// Optional feature macro: DBUS_RESPONDER_RANDOM_DELAY_EN (LFSR-driven extra latency).
package dbus_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between the core's memory stage and the responder.
// Optional feature macro: DBUS_RESPONDER_RANDOM_DELAY_EN (no effect on this file).
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_resp_ram.sv
// Backing store: 64-bit words, byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
// Optional feature macro: DBUS_RESPONDER_RANDOM_DELAY_EN (no effect on this file).
module dbus_resp_ram #(
  parameter int unsigned Depth = 4096,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [7:0]       be_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [63:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [Depth];

  // Byte-strobed write of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dbus_responder.sv
// Memory-side data-bus responder: single outstanding request, programmable latency,
// byte-strobed writes into a RAM window, sticky out-of-range and protocol-error flags.
// Optional feature macro: DBUS_RESPONDER_RANDOM_DELAY_EN adds 0..3 LFSR-chosen wait cycles.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             reset,
  dbus_responder_if.slave  bus,
  output logic             oob_err,
  output logic             proto_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
  // One extra bit so LATENCY-1 plus up to 3 extra cycles cannot wrap.
  localparam int unsigned CntW = CNT_W + 1;
`else
  localparam int unsigned CntW = CNT_W;
`endif

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  dbus_req_t       req_q;
  logic [IdxW-1:0] idx_q;
  logic            in_range_q;
  dbus_resp_t      resp_q;
  logic            oob_q;
  logic            proto_q;

  logic [63:0]     live_off;
  logic            live_in_range;
  logic [IdxW-1:0] live_idx;
  logic            sel_idle;
  logic [IdxW-1:0] rd_idx;
  logic            sel_read;
  logic            sel_in_range;
  logic [63:0]     ram_rdata;
  logic [63:0]     resp_data;
  logic            req_mismatch;
  logic            ram_we;
  logic [CntW-1:0] extra;
  logic [CntW-1:0] load_val;
  logic [CntW-1:0] cnt_dec;

  // Window decode of the live request; addr[2:0] never takes part in indexing.
  assign live_off      = bus.dreq.addr - BASE_ADDR;
  assign live_in_range = (bus.dreq.addr >= BASE_ADDR) && ((live_off >> 3) < 64'(DEPTH_WORDS));
  assign live_idx      = live_off[IdxW+2:3];

  // In IDLE the response may be formed straight from the live request (LATENCY==1 path).
  assign sel_idle     = (state_q == StIdle);
  assign rd_idx       = sel_idle ? live_idx : idx_q;
  assign sel_read     = sel_idle ? (bus.dreq.strobe == '0) : (req_q.strobe == '0);
  assign sel_in_range = sel_idle ? live_in_range : in_range_q;
  assign resp_data    = (sel_read && sel_in_range) ? ram_rdata : '0;

  assign req_mismatch = !bus.dreq.valid || (bus.dreq != req_q);

  // Write commits on the edge that ends RESP, unless reset cancels it.
  assign ram_we = (state_q == StResp) && !reset && in_range_q && (req_q.strobe != '0);

`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
  logic [15:0] lfsr_q;

  // Free-running LFSR; its low bits at acceptance pick the extra wait cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb(lfsr_q)};
    end
  end

  assign extra = CntW'(lfsr_q[1:0]);
`else
  assign extra = '0;
`endif

  assign load_val = CntW'(LATENCY - 1) + extra;
  assign cnt_dec  = cnt_q - 1'b1;

  // Request FSM with registered response and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      resp_q     <= '0;
      oob_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      resp_q <= '0;
      case (state_q)
        StIdle: begin
          if (bus.dreq.valid) begin
            req_q      <= bus.dreq;
            idx_q      <= live_idx;
            in_range_q <= live_in_range;
            cnt_q      <= load_val;
            if (!live_in_range) begin
              oob_q <= 1'b1;
            end
            if (load_val == '0) begin
              state_q <= StResp;
              resp_q  <= '{addr_ok: 1'b1, data_ok: 1'b1, data: resp_data};
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (req_mismatch) begin
            proto_q <= 1'b1;
          end
          cnt_q <= cnt_dec;
          if (cnt_dec == '0) begin
            state_q <= StResp;
            resp_q  <= '{addr_ok: 1'b1, data_ok: 1'b1, data: resp_data};
          end
        end
        StResp: begin
          if (req_mismatch) begin
            proto_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dbus_resp_ram #(
    .Depth (DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (req_q.strobe),
    .waddr_i (idx_q),
    .wdata_i (req_q.data),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  assign bus.dresp = resp_q;
  assign oob_err   = oob_q;
  assign proto_err = proto_q;

endmodule
